ov5640_init_seq: RTL and testbench

Sequencer that walks the OV5640 RAW init register ROM and issues every entry as one SCCB write to the SCCB master. Sits between the init table (registered ROM: 24-bit entry = {reg_addr[15:0], data[7:0]}, one-cycle read latency) and the SCCB write engine. Inserts the power-up wait and the post-soft-reset wait, retries NACKed writes, and reports done or error to the camera top level.

---
 rtl/ov5640_cfg_pkg.sv | 33 +++
 rtl/init_delay_cnt.sv | 31 +++
 rtl/ov5640_init_seq.sv | 167 ++++++++++++++++
 tb/tb_ov5640_init_seq.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov5640_cfg_pkg.sv
// Shared definitions for the OV5640 init sequencer: FSM encoding, soft-reset
// register identification and ROM entry field extraction.
package ov5640_cfg_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_PWR_WAIT  = 4'd0;
    localparam state_t ST_FETCH     = 4'd1;
    localparam state_t ST_LATCH     = 4'd2;
    localparam state_t ST_ISSUE     = 4'd3;
    localparam state_t ST_WAIT_DONE = 4'd4;
    localparam state_t ST_RST_WAIT  = 4'd5;
    localparam state_t ST_NEXT      = 4'd6;
    localparam state_t ST_DONE      = 4'd7;
    localparam state_t ST_ERROR     = 4'd8;

    localparam logic [15:0] SOFT_RST_REG = 16'h3008;
    localparam int          SOFT_RST_BIT = 7;

    // ROM entry layout is {reg_addr[15:0], data[7:0]}
    function automatic logic [15:0] entry_reg(input logic [23:0] entry);
        return entry[23:8];
    endfunction

    function automatic logic [7:0] entry_data(input logic [23:0] entry);
        return entry[7:0];
    endfunction

    function automatic logic is_soft_rst(input logic [15:0] reg_addr, input logic [7:0] data);
        return (reg_addr == SOFT_RST_REG) && data[SOFT_RST_BIT];
    endfunction

endpackage

// File: rtl/init_delay_cnt.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module init_delay_cnt #(
    parameter int             CW      = 8,
    parameter logic [CW-1:0]  RST_VAL = {CW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          done
);

    logic [CW-1:0] cnt_r;

    // Count down while enabled, saturating at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= RST_VAL;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != {CW{1'b0}})) begin
            cnt_r <= cnt_r - CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/ov5640_init_seq.sv
// Walks the OV5640 init ROM and issues each entry as one SCCB write, with
// power-up and soft-reset waits, NACK retries and done/error reporting.
module ov5640_init_seq
    import ov5640_cfg_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int TABLE_LEN   = 82,
    parameter int PWR_DLY_CYC = 1_000_000,
    parameter int RST_DLY_CYC = 250_000,
    parameter int RETRY_MAX   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  re_init,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [23:0]           rom_q,
    output logic                  wr_req,
    output logic [15:0]           wr_reg_addr,
    output logic [7:0]            wr_data,
    input  logic                  wr_ack,
    input  logic                  wr_done,
    input  logic                  wr_err,
    output logic                  busy,
    output logic                  init_done,
    output logic                  init_err,
    output logic [ADDR_WIDTH-1:0] err_index
);

    localparam int DLY_MAX = (PWR_DLY_CYC > RST_DLY_CYC) ? PWR_DLY_CYC : RST_DLY_CYC;
    localparam int CW      = $clog2(DLY_MAX) + 1;
    localparam int RW      = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

    localparam logic [CW-1:0]         PWR_LOAD  = CW'(PWR_DLY_CYC - 1);
    localparam logic [CW-1:0]         RST_LOAD  = CW'(RST_DLY_CYC - 1);
    localparam logic [RW-1:0]         RETRY_LIM = RW'(RETRY_MAX);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(TABLE_LEN - 1);

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   idx_r;
    logic [RW-1:0]           retry_r;

    logic                    done_evt_s;
    logic                    soft_s;
    logic                    load_rst_s;
    logic                    load_pwr_s;
    logic                    dly_load_s;
    logic [CW-1:0]           dly_val_s;
    logic                    dly_en_s;
    logic                    dly_done_s;

    // A done accompanying the ack in ISSUE is resolved immediately
    assign done_evt_s = wr_done && ((state_r == ST_WAIT_DONE) || ((state_r == ST_ISSUE) && wr_ack));
    assign soft_s     = is_soft_rst(wr_reg_addr, wr_data);
    assign load_rst_s = done_evt_s && !wr_err && soft_s;
    assign load_pwr_s = re_init && ((state_r == ST_DONE) || (state_r == ST_ERROR));
    assign dly_load_s = load_rst_s || load_pwr_s;
    assign dly_en_s   = (state_r == ST_PWR_WAIT) || (state_r == ST_RST_WAIT);

    // Pick the reload value for whichever wait state is being entered
    always_comb begin
        dly_val_s = RST_LOAD;
        if (load_pwr_s) begin
            dly_val_s = PWR_LOAD;
        end else begin
            dly_val_s = RST_LOAD;
        end
    end

    init_delay_cnt #(
        .CW      (CW),
        .RST_VAL (PWR_LOAD)
    ) u_dly (
        .clk      (clk),
        .rst      (rst),
        .load     (dly_load_s),
        .load_val (dly_val_s),
        .en       (dly_en_s),
        .done     (dly_done_s)
    );

    // Sequencer FSM with registered write interface and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_PWR_WAIT;
            idx_r       <= {ADDR_WIDTH{1'b0}};
            retry_r     <= {RW{1'b0}};
            rom_addr    <= {ADDR_WIDTH{1'b0}};
            wr_req      <= 1'b0;
            wr_reg_addr <= 16'h0000;
            wr_data     <= 8'h00;
            busy        <= 1'b1;
            init_done   <= 1'b0;
            init_err    <= 1'b0;
            err_index   <= {ADDR_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_PWR_WAIT: begin
                    if (dly_done_s) begin
                        idx_r    <= {ADDR_WIDTH{1'b0}};
                        rom_addr <= {ADDR_WIDTH{1'b0}};
                        state_r  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_LATCH;
                end
                ST_LATCH: begin
                    wr_reg_addr <= entry_reg(rom_q);
                    wr_data     <= entry_data(rom_q);
                    retry_r     <= {RW{1'b0}};
                    wr_req      <= 1'b1;
                    state_r     <= ST_ISSUE;
                end
                ST_ISSUE, ST_WAIT_DONE: begin
                    if ((state_r == ST_ISSUE) && wr_ack) begin
                        wr_req  <= 1'b0;
                        state_r <= ST_WAIT_DONE;
                    end
                    // Later assignments override the ack handling above
                    if (done_evt_s) begin
                        if (!wr_err) begin
                            state_r <= soft_s ? ST_RST_WAIT : ST_NEXT;
                        end else if (retry_r < RETRY_LIM) begin
                            retry_r <= retry_r + RW'(1);
                            wr_req  <= 1'b1;
                            state_r <= ST_ISSUE;
                        end else begin
                            err_index <= idx_r;
                            busy      <= 1'b0;
                            init_err  <= 1'b1;
                            state_r   <= ST_ERROR;
                        end
                    end
                end
                ST_RST_WAIT: begin
                    if (dly_done_s) begin
                        state_r <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (idx_r == LAST_IDX) begin
                        busy      <= 1'b0;
                        init_done <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        idx_r    <= idx_r + ADDR_WIDTH'(1);
                        rom_addr <= idx_r + ADDR_WIDTH'(1);
                        state_r  <= ST_FETCH;
                    end
                end
                ST_DONE, ST_ERROR: begin
                    if (re_init) begin
                        idx_r     <= {ADDR_WIDTH{1'b0}};
                        busy      <= 1'b1;
                        init_done <= 1'b0;
                        init_err  <= 1'b0;
                        state_r   <= ST_PWR_WAIT;
                    end
                end
                default: begin
                    state_r <= ST_PWR_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ov5640_init_seq.sv
// Directed bench for ov5640_init_seq: ROM model, SCCB responder model and a
// write monitor, with hand-computed expected write sequences and timings.
module tb_ov5640_init_seq;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          re_init;
    logic [AW-1:0] rom_addr;
    logic [23:0]   rom_q = 24'h0;
    logic          wr_req;
    logic [15:0]   wr_reg_addr;
    logic [7:0]    wr_data;
    logic          wr_ack;
    logic          wr_done;
    logic          wr_err;
    logic          busy;
    logic          init_done;
    logic          init_err;
    logic [AW-1:0] err_index;

    ov5640_init_seq #(
        .ADDR_WIDTH  (AW),
        .TABLE_LEN   (4),
        .PWR_DLY_CYC (10),
        .RST_DLY_CYC (20),
        .RETRY_MAX   (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .re_init     (re_init),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .wr_req      (wr_req),
        .wr_reg_addr (wr_reg_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .wr_done     (wr_done),
        .wr_err      (wr_err),
        .busy        (busy),
        .init_done   (init_done),
        .init_err    (init_err),
        .err_index   (err_index)
    );

    always #5 clk = ~clk;

    logic [23:0] rom [4] = '{24'h310303, 24'h300882, 24'h430003, 24'h303541};

    always @(posedge clk) rom_q <= (rom_addr < 8'd4) ? rom[rom_addr[1:0]] : 24'h000000;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: logs each rising wr_req and each wr_done, with cycle stamps
    logic [23:0] wlog[$];
    int          req_cyc[$];
    int          done_cyc[$];
    logic        req_q = 1'b0;
    always begin
        @(posedge clk);
        #1;
        if (wr_req && !req_q) begin
            wlog.push_back({wr_reg_addr, wr_data});
            req_cyc.push_back(cyc);
        end
        if (wr_done) done_cyc.push_back(cyc);
        req_q = wr_req;
    end

    // SCCB responder model
    int          ack_dly   = 2;
    int          done_dly  = 5;
    bit          same_cyc  = 1'b0;
    logic [15:0] nack_addr = 16'hFFFF;
    int          nack_left = 0;
    bit          resp_nk;
    initial begin
        wr_ack  = 1'b0;
        wr_done = 1'b0;
        wr_err  = 1'b0;
        forever begin
            @(negedge clk);
            if (wr_req) begin
                resp_nk = (wr_reg_addr == nack_addr) && (nack_left > 0);
                if (resp_nk) nack_left = nack_left - 1;
                repeat (ack_dly - 1) @(negedge clk);
                wr_ack = 1'b1;
                if (same_cyc) begin
                    wr_done = 1'b1;
                    wr_err  = resp_nk;
                end
                @(negedge clk);
                wr_ack  = 1'b0;
                wr_done = 1'b0;
                wr_err  = 1'b0;
                if (!same_cyc) begin
                    repeat (done_dly - 1) @(negedge clk);
                    wr_done = 1'b1;
                    wr_err  = resp_nk;
                    @(negedge clk);
                    wr_done = 1'b0;
                    wr_err  = 1'b0;
                end
            end
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int rel    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic check_log(input string tag, input logic [23:0] exp [8], input int n);
        chk({tag, " count"}, wlog.size(), n);
        for (int i = 0; i < n && i < wlog.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), wlog[i], exp[i]);
    endtask

    task automatic clear_mon();
        wlog.delete();
        req_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        clear_mon();
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(init_done || init_err) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " finished"}, (n < 1000), 1);
    endtask

    logic [23:0] exp_good [8] = '{24'h310303, 24'h300882, 24'h430003, 24'h303541, 0, 0, 0, 0};
    logic [23:0] exp_nack2 [8] = '{24'h310303, 24'h300882, 24'h430003, 24'h430003,
                                   24'h430003, 24'h303541, 0, 0};
    logic [23:0] exp_err [8] = '{24'h310303, 24'h300882, 24'h300882, 24'h300882,
                                 24'h300882, 0, 0, 0};

    initial begin
        int n;
        rst     = 1'b1;
        re_init = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst rom_addr", rom_addr, 0);
        chk("rst wr_req", wr_req, 0);
        chk("rst wr_reg_addr", wr_reg_addr, 0);
        chk("rst wr_data", wr_data, 0);
        chk("rst busy", busy, 1);
        chk("rst init_done", init_done, 0);
        chk("rst init_err", init_err, 0);
        chk("rst err_index", err_index, 0);

        // T1: clean run with a soft-reset entry
        @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        clear_mon();
        wait_end("t1");
        chk("t1 first req latency", req_cyc[0] - rel, 12);
        check_log("t1 log", exp_good, 4);
        chk("t1 normal gap", req_cyc[1] - done_cyc[0], 3);
        chk("t1 soft rst gap", req_cyc[2] - done_cyc[1], 23);
        chk("t1 init_done", init_done, 1);
        chk("t1 busy", busy, 0);
        chk("t1 init_err", init_err, 0);

        // T2: entry 2 NACKed twice then accepted
        nack_addr = 16'h4300;
        nack_left = 2;
        do_reset();
        wait_end("t2");
        check_log("t2 log", exp_nack2, 6);
        chk("t2 init_done", init_done, 1);
        chk("t2 init_err", init_err, 0);

        // T3: entry 1 NACKed on every attempt
        nack_addr = 16'h3008;
        nack_left = 4;
        do_reset();
        wait_end("t3");
        chk("t3 init_err", init_err, 1);
        chk("t3 init_done", init_done, 0);
        chk("t3 err_index", err_index, 1);
        chk("t3 busy", busy, 0);
        repeat (30) @(negedge clk);
        check_log("t3 log", exp_err, 5);

        // T4: re_init out of ERROR replays the table
        @(negedge clk);
        re_init = 1'b1;
        rel = cyc;
        clear_mon();
        @(negedge clk);
        re_init = 1'b0;
        chk("t4 init_err cleared", init_err, 0);
        chk("t4 busy", busy, 1);
        wait_end("t4");
        chk("t4 first req latency", req_cyc[0] - rel, 13);
        check_log("t4 log", exp_good, 4);
        chk("t4 init_done", init_done, 1);

        // T5: reset while entry 2 waits for done; its done arrives as a stray
        done_dly = 8;
        do_reset();
        n = 0;
        while (!(wlog.size() == 3 && !wr_req) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t5 reached wait_done", (n < 500), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5 wr_req after rst", wr_req, 0);
        @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        clear_mon();
        wait_end("t5");
        chk("t5 first req latency", req_cyc[0] - rel, 12);
        check_log("t5 log", exp_good, 4);
        chk("t5 init_done", init_done, 1);

        // T5b: reset while wr_req is asserted
        done_dly = 5;
        do_reset();
        n = 0;
        while (!(wlog.size() == 3 && wr_req) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t5b reached issue", (n < 500), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5b wr_req dropped", wr_req, 0);
        @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        clear_mon();
        wait_end("t5b");
        check_log("t5b log", exp_good, 4);
        chk("t5b init_done", init_done, 1);

        // T6: ack and done together; re_init pulses while busy are ignored
        same_cyc = 1'b1;
        do_reset();
        repeat (3) @(negedge clk);
        re_init = 1'b1;
        @(negedge clk);
        re_init = 1'b0;
        n = 0;
        while (wlog.size() < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        re_init = 1'b1;
        @(negedge clk);
        re_init = 1'b0;
        wait_end("t6");
        chk("t6 first req latency", req_cyc[0] - rel, 12);
        chk("t6 normal gap", req_cyc[1] - done_cyc[0], 3);
        check_log("t6 log", exp_good, 4);
        chk("t6 init_done", init_done, 1);
        chk("t6 init_err", init_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
